// File: rtl/game_pkg.sv
// Shared types and constants for the 4x4 tile game datapath.
// Cell i of a packed board occupies board[63-4*i -: 4]; code 0 marks an empty cell.
package game_pkg;

   localparam int CELL_W  = 4;
   localparam int N_CELLS = 16;
   localparam logic [3:0] EMPTY = 4'd0;

   typedef logic [CELL_W-1:0]         cell_t;
   typedef logic [N_CELLS*CELL_W-1:0] board_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PROBE = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      FULL  = 3'd4
   } spawn_state_t;

   function automatic cell_t cell_at(input board_t b, input logic [3:0] i);
      return b[(N_CELLS - 1 - int'(i)) * CELL_W +: CELL_W];
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left every cycle.
// A zero seed would lock the register, so it is replaced by 16'h0001.
module lfsr16 (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic feedback;

   assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

   // Seed load on reset, otherwise shift in the feedback bit.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         q <= (seed == 16'd0) ? 16'h0001 : seed;
      end else begin
         q <= {q[14:0], feedback};
      end
   end

endmodule

// File: rtl/tile_spawn_ctrl.sv
// Places one new tile after each accepted move: random start cell, wrap-around probe, one write.
// Optional macro SPAWN_FOUR_EN: spawn a 4 instead of NEW_TILE when lfsr[6:4]==0 at request time.
module tile_spawn_ctrl
   import game_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter cell_t       NEW_TILE  = 4'd2
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        spawn_req,
   input  board_t      board,
   output logic        busy,
   output logic        wr_en,
   output logic [3:0]  wr_idx,
   output logic [3:0]  wr_val,
   output logic        done,
   output logic        board_full
);

   spawn_state_t state;
   spawn_state_t state_next;
   board_t       snap;
   logic [3:0]   idx;
   logic [3:0]   cnt;
   cell_t        val;
   cell_t        draw_val;
   logic [15:0]  lfsr_q;
   logic         lfsr_unused;

   lfsr16 u_lfsr (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .seed     (LFSR_SEED),
      .q        (lfsr_q)
   );

`ifdef SPAWN_FOUR_EN
   assign draw_val    = (lfsr_q[6:4] == 3'b000) ? 4'd4 : NEW_TILE;
   assign lfsr_unused = ^lfsr_q[15:7];
`else
   assign draw_val    = NEW_TILE;
   assign lfsr_unused = ^lfsr_q[15:4];
`endif

   // Next-state decode; PROBE examines one snapshot cell per cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (spawn_req) begin
               state_next = PROBE;
            end else begin
               state_next = IDLE;
            end
         end
         PROBE: begin
            if (cell_at(snap, idx) == EMPTY) begin
               state_next = WRITE;
            end else if (cnt == 4'd15) begin
               state_next = FULL;
            end else begin
               state_next = PROBE;
            end
         end
         WRITE:   state_next = DONE;
         DONE:    state_next = IDLE;
         FULL:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, request capture, probe counters and outputs registered from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= IDLE;
         snap       <= '0;
         idx        <= 4'd0;
         cnt        <= 4'd0;
         val        <= 4'd0;
         busy       <= 1'b0;
         wr_en      <= 1'b0;
         wr_idx     <= 4'd0;
         wr_val     <= 4'd0;
         done       <= 1'b0;
         board_full <= 1'b0;
      end else begin
         state <= state_next;
         if ((state == IDLE) && spawn_req) begin
            snap <= board;
            idx  <= lfsr_q[3:0];
            cnt  <= 4'd0;
            val  <= draw_val;
         end else if ((state == PROBE) && (state_next == PROBE)) begin
            idx <= idx + 4'd1;
            cnt <= cnt + 4'd1;
         end
         busy       <= (state_next != IDLE);
         wr_en      <= (state_next == WRITE);
         wr_idx     <= (state_next == WRITE) ? idx : 4'd0;
         wr_val     <= (state_next == WRITE) ? val : 4'd0;
         done       <= (state_next == DONE) || (state_next == FULL);
         board_full <= (state_next == FULL);
      end
   end

endmodule

// File: tb/tb_tile_spawn_ctrl.sv
// Scoreboard bench for tile_spawn_ctrl: directed requests push expected writes/dones, a monitor checks them.
// Honours SPAWN_FOUR_EN when computing the expected tile value.
module tb_tile_spawn_ctrl;
   import game_pkg::*;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       spawn_req;
   board_t     board;
   logic       busy, wr_en, done, board_full;
   logic [3:0] wr_idx, wr_val;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [15:0] m;

   typedef struct {int cyc; logic [3:0] idx; logic [3:0] val;} wr_exp_t;
   typedef struct {int cyc; logic full;} dn_exp_t;
   wr_exp_t wq[$];
   dn_exp_t dq[$];

   always #10 CLOCK_50 = ~CLOCK_50;

   tile_spawn_ctrl dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .spawn_req  (spawn_req),
      .board      (board),
      .busy       (busy),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_val     (wr_val),
      .done       (done),
      .board_full (board_full)
   );

   // Reference LFSR and cycle counter (cycle = number of rising edges seen)
   always @(posedge CLOCK_50) begin
      cyc <= cyc + 1;
      if (reset) m <= 16'hACE1;
      else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the head of its queue, including its cycle
   always @(negedge CLOCK_50) begin
      wr_exp_t we;
      dn_exp_t de;
      if (reset === 1'b0) begin
         if (wr_en) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_wr_en actual=1 required=0 cyc=%0d", cyc);
            end else begin
               we = wq.pop_front();
               check("wr_cycle", cyc, we.cyc);
               check("wr_idx", {28'd0, wr_idx}, {28'd0, we.idx});
               check("wr_val", {28'd0, wr_val}, {28'd0, we.val});
            end
         end
         if (done) begin
            if (dq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
               de = dq.pop_front();
               check("done_cycle", cyc, de.cyc);
               check("board_full", {31'd0, board_full}, {31'd0, de.full});
            end
         end
      end
   end

   function automatic board_t with_cell(input board_t b, input int i, input logic [3:0] v);
      board_t r;
      r = b;
      r[63 - 4*i -: 4] = v;
      return r;
   endfunction

   // One request from IDLE. start<0: any start cell; exp_idx<0: expect the start cell itself.
   task automatic spawn(input board_t b, input int start, input int exp_idx, input int skips,
                        input bit full, input board_t b_after);
      int n;
      int s;
      wr_exp_t we;
      logic [3:0] v;
      board = b;
      n = 0;
      if (start >= 0) begin
         while ((m[3:0] != start[3:0]) && (n < 200)) begin
            @(negedge CLOCK_50);
            n++;
         end
         if (m[3:0] != start[3:0]) begin
            checks++; failures++;
            $display("FAIL start_wait actual=%0d required=%0d", m[3:0], start);
            return;
         end
      end
      s = cyc + 1;
`ifdef SPAWN_FOUR_EN
      v = (m[6:4] == 3'b000) ? 4'd4 : 4'd2;
`else
      v = 4'd2;
`endif
      if (full) begin
         dq.push_back('{s + 16, 1'b1});
      end else begin
         we.cyc = s + 1 + skips;
         we.idx = (exp_idx < 0) ? m[3:0] : exp_idx[3:0];
         we.val = v;
         wq.push_back(we);
         dq.push_back('{s + 2 + skips, 1'b0});
      end
      spawn_req = 1'b1;
      @(negedge CLOCK_50);
      spawn_req = 1'b0;
      board = b_after;
      n = 0;
      while ((dq.size() != 0) && (n < 40)) begin
         @(negedge CLOCK_50);
         n++;
      end
      if (dq.size() != 0) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=%0d required=0", dq.size());
         wq.delete();
         dq.delete();
      end
      @(negedge CLOCK_50);
      check("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check({tag, "_wr_idx"}, {28'd0, wr_idx}, 32'd0);
      check({tag, "_wr_val"}, {28'd0, wr_val}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
      check({tag, "_board_full"}, {31'd0, board_full}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      board_t b;
      reset     = 1'b1;
      spawn_req = 1'b0;
      board     = '0;
      repeat (3) @(negedge CLOCK_50);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge CLOCK_50);

      // 1: empty board, start cell 5
      spawn('0, 5, 5, 0, 1'b0, '0);

      // 2: cells 5..9 occupied; board changes after sampling must not matter
      b = '0;
      for (int i = 5; i <= 9; i++) b = with_cell(b, i, 4'd2);
      spawn(b, 5, 10, 5, 1'b0, {64{1'b1}});

      // 3: wrap-around, only cell 0 empty, start at 14
      spawn(64'h0FFF_FFFF_FFFF_FFFF, 14, 0, 2, 1'b0, '0);

      // 4: full board
      spawn(64'h1111_1111_1111_1111, -1, 0, 0, 1'b1, 64'h1111_1111_1111_1111);

      // 5: reset during a long probe aborts the request
      board     = 64'h2222_2222_2222_2222;
      spawn_req = 1'b1;
      @(negedge CLOCK_50);
      spawn_req = 1'b0;
      board     = '0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      check("busy_mid_probe", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check_outputs_zero("abort");
      reset = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check_outputs_zero("post_abort");
      spawn('0, -1, -1, 0, 1'b0, '0);

      // 6: many requests on an empty board, tile value follows lfsr[6:4]
      for (int r = 0; r < 1000; r++) spawn('0, -1, -1, 0, 1'b0, '0);

      repeat (5) @(negedge CLOCK_50);
      check("queues_drained", wq.size() + dq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
